// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the BCD display scan controller.
package bcd_scan_pkg;

  // Scan sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam int unsigned BCD_W = 4;  // width of one BCD digit
  localparam int unsigned NIB_W = 4;  // width of one channel value

endpackage : bcd_scan_pkg

// File: rtl/bin4_bcd_conv.sv
// Combinational 4-bit binary to two-digit BCD converter (0..15 -> tens 0/1, ones 0..9).
module bin4_bcd_conv
  import bcd_scan_pkg::*;
(
  input  logic [NIB_W-1:0] bin_in,
  output logic [BCD_W-1:0] tens_out,
  output logic [BCD_W-1:0] ones_out
);

  logic ge_ten;

  // Values 10..15 carry into the tens digit; everything else is a single digit
  always_comb begin
    ge_ten   = (bin_in >= NIB_W'(10));
    tens_out = ge_ten ? BCD_W'(1) : BCD_W'(0);
    ones_out = ge_ten ? BCD_W'(bin_in - NIB_W'(10)) : BCD_W'(bin_in);
  end

endmodule : bin4_bcd_conv

// File: rtl/bcd_scan_ctrl.sv
// Multiplexed 7-seg scan controller: snapshots NUM_CH nibbles, converts each to
// two BCD digits through one shared converter and scans the 2*NUM_CH digits
// with a blanking guard between slots.
// Optional feature macro: BCD_LEAD_ZERO_BLANK_EN (suppress a zero tens digit).
module bcd_scan_ctrl
  import bcd_scan_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [NIB_W*NUM_CH-1:0] ch_val,
  output logic [2*NUM_CH-1:0]   digit_sel,
  output logic [BCD_W-1:0]      bcd_out,
  output logic                  frame_done
);

  localparam int unsigned NUM_DIG = 2 * NUM_CH;
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IDX_W   = CH_W + 1;
  localparam int unsigned CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);

  scan_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NIB_W*NUM_CH-1:0]     shadow_q, shadow_d;
  logic                        pend_q, pend_d;
  logic [NUM_DIG-1:0]          sel_q, sel_d;
  logic [BCD_W-1:0]            bcd_q, bcd_d;
  logic                        fd_q, fd_d;

  logic [NIB_W-1:0]            ch_nib [NUM_CH];
  logic [NIB_W-1:0]            conv_in;
  logic [BCD_W-1:0]            conv_tens;
  logic [BCD_W-1:0]            conv_ones;
  logic [BCD_W-1:0]            conv_digit;
  logic [NUM_DIG-1:0]          drive_sel;
  logic [NUM_DIG-1:0]          slot_sel;

  // Split the shadow snapshot into per-channel nibbles
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_nib
      assign ch_nib[gi] = shadow_q[NIB_W*gi +: NIB_W];
    end
  endgenerate

  // Active-low one-hot select for the current digit index
  generate
    for (gi = 0; gi < NUM_DIG; gi++) begin : g_sel
      assign drive_sel[gi] = (idx_q != IDX_W'(gi));
    end
  endgenerate

  // Channel for digit idx is idx>>1; odd digits are tens, even digits ones
  assign conv_in = ch_nib[idx_q[IDX_W-1:1]];

  bin4_bcd_conv u_conv (
    .bin_in   (conv_in),
    .tens_out (conv_tens),
    .ones_out (conv_ones)
  );

  assign conv_digit = idx_q[0] ? conv_tens : conv_ones;

  // Select pattern latched at slot start; a zero tens digit may stay dark
  always_comb begin
`ifdef BCD_LEAD_ZERO_BLANK_EN
    if (idx_q[0] && (conv_tens == BCD_W'(0))) begin
      slot_sel = '1;
    end else begin
      slot_sel = drive_sel;
    end
`else
    slot_sel = drive_sel;
`endif
  end

  // Next-state logic for the scan sequencer, snapshot and output registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    pend_d   = pend_q | load;
    sel_d    = sel_q;
    bcd_d    = bcd_q;
    fd_d     = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      sel_d   = '1;
      bcd_d   = '0;
      // While already idle a request is applied straight away
      if ((state_q == ST_IDLE) && (load || pend_q)) begin
        shadow_d = ch_val;
        pend_d   = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          sel_d   = '1;
          bcd_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_BLANK;
          if (load || pend_q) begin
            shadow_d = ch_val;
            pend_d   = 1'b0;
          end
        end
        ST_BLANK: begin
          sel_d = '1;
          if (cnt_q == GUARD_LAST) begin
            cnt_d   = '0;
            state_d = ST_DRIVE;
            sel_d   = slot_sel;
            bcd_d   = conv_digit;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            sel_d   = '1;
            if (idx_q == IDX_LAST) begin
              // Frame boundary: the only point a new snapshot may land mid-scan
              idx_d = '0;
              fd_d  = 1'b1;
              if (load || pend_q) begin
                shadow_d = ch_val;
                pend_d   = 1'b0;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          sel_d   = '1;
        end
      endcase
    end
  end

  // State and registered outputs, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      sel_q    <= '1;
      bcd_q    <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      sel_q    <= sel_d;
      bcd_q    <= bcd_d;
      fd_q     <= fd_d;
    end
  end

  assign digit_sel  = sel_q;
  assign bcd_out    = bcd_q;
  assign frame_done = fd_q;

endmodule : bcd_scan_ctrl

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl (NUM_CH=2, REFRESH_DIV=4, GUARD_CYC=1).
// Follows BCD_LEAD_ZERO_BLANK_EN if the build defines it.
module tb_bcd_scan_ctrl;

`ifdef BCD_LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk;
  logic       clk_run;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] ch_val;
  logic [3:0] digit_sel;
  logic [3:0] bcd_out;
  logic       frame_done;

  int total_cnt;
  int bad_cnt;

  bcd_scan_ctrl #(
    .NUM_CH      (2),
    .REFRESH_DIV (4),
    .GUARD_CYC   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .ch_val     (ch_val),
    .digit_sel  (digit_sel),
    .bcd_out    (bcd_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Expected select for digit d showing value v
  function automatic logic [3:0] exp_sel(input int d, input int v);
    logic [3:0] s;
    s = 4'b1111;
    if (!(LZB && (d % 2 == 1) && (v == 0))) s[d] = 1'b0;
    return s;
  endfunction

  // One blank cycle then n_drive cycles of digit d; optional mid-slot load
  task automatic check_slot(input int d, input int v, input logic fd_blank,
                            input int n_drive, input bit do_load, input logic [7:0] new_val);
    @(negedge clk);
    chk("blank_sel", {28'd0, digit_sel}, 32'hF);
    chk("blank_fd", {31'd0, frame_done}, {31'd0, fd_blank});
    for (int i = 0; i < n_drive; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (do_load && i == 1) begin
        ch_val = new_val;
        load   = 1'b1;
      end
      chk("drive_sel", {28'd0, digit_sel}, {28'd0, exp_sel(d, v)});
      chk("drive_bcd", {28'd0, bcd_out}, v);
      chk("drive_fd", {31'd0, frame_done}, 32'd0);
    end
    $display("slot digit=%0d sel=%b bcd=%0d fd_blank=%0b", d, digit_sel, bcd_out, fd_blank);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    clk_run   = 1'b0;
    rst       = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    ch_val    = 8'd0;

    // Reset with no clock running
    #2 rst = 1'b1;
    #1;
    chk("rst_sel", {28'd0, digit_sel}, 32'hF);
    chk("rst_bcd", {28'd0, bcd_out}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    $display("reset sel=%b bcd=%0d fd=%0b", digit_sel, bcd_out, frame_done);

    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Snapshot {13,7} while idle, then enable
    @(negedge clk);
    ch_val = {4'd13, 4'd7};
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("idle_sel", {28'd0, digit_sel}, 32'hF);
    en = 1'b1;

    // Frame 1: 7,0,3,1
    check_slot(0, 7, 1'b0, 4, 1'b0, 8'd0);
    check_slot(1, 0, 1'b0, 4, 1'b0, 8'd0);
    check_slot(2, 3, 1'b0, 4, 1'b0, 8'd0);
    check_slot(3, 1, 1'b0, 4, 1'b0, 8'd0);

    // Frame 2: load {2,9} during digit 1; digits 2,3 keep old snapshot
    check_slot(0, 7, 1'b1, 4, 1'b0, 8'd0);
    check_slot(1, 0, 1'b0, 4, 1'b1, {4'd2, 4'd9});
    check_slot(2, 3, 1'b0, 4, 1'b0, 8'd0);
    check_slot(3, 1, 1'b0, 4, 1'b0, 8'd0);

    // Frame 3: new snapshot 9,0,2,0
    check_slot(0, 9, 1'b1, 4, 1'b0, 8'd0);
    check_slot(1, 0, 1'b0, 4, 1'b0, 8'd0);
    check_slot(2, 2, 1'b0, 4, 1'b0, 8'd0);
    check_slot(3, 0, 1'b0, 4, 1'b0, 8'd0);

    // Frame 4: drop enable during digit 2
    check_slot(0, 9, 1'b1, 4, 1'b0, 8'd0);
    check_slot(1, 0, 1'b0, 4, 1'b0, 8'd0);
    check_slot(2, 2, 1'b0, 1, 1'b0, 8'd0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("off_sel", {28'd0, digit_sel}, 32'hF);
      chk("off_fd", {31'd0, frame_done}, 32'd0);
    end
    $display("disabled sel=%b fd=%0b", digit_sel, frame_done);
    en = 1'b1;
    check_slot(0, 9, 1'b0, 4, 1'b0, 8'd0);

    // Async reset between edges mid-drive
    check_slot(1, 0, 1'b0, 2, 1'b0, 8'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", {28'd0, digit_sel}, 32'hF);
    chk("arst_bcd", {28'd0, bcd_out}, 32'd0);
    chk("arst_fd", {31'd0, frame_done}, 32'd0);
    $display("async reset sel=%b bcd=%0d fd=%0b", digit_sel, bcd_out, frame_done);
    @(negedge clk);
    rst = 1'b0;
    // Shadow was cleared, so the restarted scan shows zeros from digit 0
    check_slot(0, 0, 1'b0, 4, 1'b0, 8'd0);
    check_slot(1, 0, 1'b0, 4, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule : tb_bcd_scan_ctrl
